// File: rtl/fb_writer.sv
// Framebuffer writer: plot / rectangle-fill commands -> one video-RAM write per cycle.
// Optional full-screen clear (op 2) is built when FB_WRITER_CLEAR_EN is defined.
module fb_writer #(
  parameter int FB_W   = 320,
  parameter int FB_H   = 240,
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [8:0]        cmd_x0,
  input  logic [7:0]        cmd_y0,
  input  logic [8:0]        cmd_x1,
  input  logic [7:0]        cmd_y1,
  input  logic [3:0]        cmd_color,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [3:0]        wr_data,
  output logic              busy,
  output logic              done
);

  localparam logic [8:0] XMAX = 9'(FB_W - 1);
  localparam logic [7:0] YMAX = 8'(FB_H - 1);

`ifdef FB_WRITER_CLEAR_EN
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_W * FB_H - 1);
  typedef enum logic [1:0] {IDLE, PLOT, FILL, CLEAR} state_e;
`else
  typedef enum logic [1:0] {IDLE, PLOT, FILL} state_e;
`endif

  // y*FB_W as a sum of shifted copies of y, one term per set bit of FB_W.
  function automatic logic [ADDR_W-1:0] row_of(input logic [7:0] y);
    logic [ADDR_W-1:0] acc;
    acc = '0;
    for (int b = 0; b < 32; b++)
      if (FB_W[b]) acc = acc + (ADDR_W'(y) << b);
    return acc;
  endfunction

  state_e            state_q;
  logic              wr_en_q, done_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [3:0]        wr_data_q;
  logic [8:0]        x0_q, ex_q, cx_q, cx_d, acc_ex;
  logic [7:0]        ey_q, cy_q, cy_d, acc_ey;
  logic [ADDR_W-1:0] row_q, row_d, acc_row, acc_addr;
  logic              acc_inside, acc_empty;

  always_comb begin
    acc_ex     = (cmd_x1 > XMAX) ? XMAX : cmd_x1;
    acc_ey     = (cmd_y1 > YMAX) ? YMAX : cmd_y1;
    acc_inside = (cmd_x0 <= XMAX) && (cmd_y0 <= YMAX);
    acc_empty  = !acc_inside || (cmd_x0 > acc_ex) || (cmd_y0 > acc_ey);
    acc_row    = row_of(cmd_y0);
    acc_addr   = acc_row + ADDR_W'(cmd_x0);
    // Raster step from the pixel currently on the write port to the next one.
    if (cx_q == ex_q) begin
      cx_d  = x0_q;
      cy_d  = cy_q + 8'd1;
      row_d = row_q + ADDR_W'(FB_W);
    end else begin
      cx_d  = cx_q + 9'd1;
      cy_d  = cy_q;
      row_d = row_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      wr_en_q   <= 1'b0;
      done_q    <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      x0_q      <= '0;
      ex_q      <= '0;
      ey_q      <= '0;
      cx_q      <= '0;
      cy_q      <= '0;
      row_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          wr_en_q <= 1'b0;
          done_q  <= 1'b0;
          if (cmd_valid) begin
            case (cmd_op)
              2'd0: begin
                state_q <= PLOT;
                done_q  <= 1'b1;
                if (acc_inside) begin
                  wr_en_q   <= 1'b1;
                  wr_addr_q <= acc_addr;
                  wr_data_q <= cmd_color;
                end
              end
              2'd1: begin
                x0_q <= cmd_x0;
                ex_q <= acc_ex;
                ey_q <= acc_ey;
                if (acc_empty) begin
                  state_q <= PLOT;
                  done_q  <= 1'b1;
                end else begin
                  // First pixel goes out immediately; counters track it.
                  state_q   <= FILL;
                  wr_en_q   <= 1'b1;
                  wr_addr_q <= acc_addr;
                  wr_data_q <= cmd_color;
                  cx_q      <= cmd_x0;
                  cy_q      <= cmd_y0;
                  row_q     <= acc_row;
                  done_q    <= (cmd_x0 == acc_ex) && (cmd_y0 == acc_ey);
                end
              end
`ifdef FB_WRITER_CLEAR_EN
              2'd2: begin
                state_q   <= CLEAR;
                wr_en_q   <= 1'b1;
                wr_addr_q <= '0;
                wr_data_q <= cmd_color;
                done_q    <= 1'b0;
              end
`endif
              default: begin
                state_q <= PLOT;
                done_q  <= 1'b1;
              end
            endcase
          end
        end
        PLOT: begin
          state_q <= IDLE;
          wr_en_q <= 1'b0;
          done_q  <= 1'b0;
        end
        FILL: begin
          if (done_q) begin
            state_q <= IDLE;
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
          end else begin
            cx_q      <= cx_d;
            cy_q      <= cy_d;
            row_q     <= row_d;
            wr_addr_q <= row_d + ADDR_W'(cx_d);
            done_q    <= (cx_d == ex_q) && (cy_d == ey_q);
          end
        end
`ifdef FB_WRITER_CLEAR_EN
        CLEAR: begin
          if (done_q) begin
            state_q <= IDLE;
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
          end else begin
            wr_addr_q <= wr_addr_q + 1'b1;
            done_q    <= (wr_addr_q == LAST_ADDR - 1'b1);
          end
        end
`endif
        default: begin
          state_q <= IDLE;
          wr_en_q <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign done      = done_q;

endmodule
